pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, giving the bits per data lane.
REQ-002 The block SHALL provide parameter LANES, default 2, giving the number of data lanes carried per transfer (lane 0 = bits WIDTH-1:0).
REQ-003 The block SHALL provide parameter CTRL_W, default 2, giving the width of the control-bit bundle (for example regwrite or memtoreg).
REQ-004 The block SHALL provide port CLK, input, 1 bit: stage clock; all state updates on the falling edge.
REQ-005 The block SHALL provide port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL provide port FLUSH, input, 1 bit: synchronous bubble insertion.
REQ-007 The block SHALL provide port IN_VALID, input, 1 bit: upstream offers a transfer.
REQ-008 The block SHALL provide port IN_READY, output, 1 bit: the stage accepts a transfer.
REQ-009 The block SHALL provide port IN_CTRL, input, CTRL_W bits: control bits of the offered transfer.
REQ-010 The block SHALL provide port IN_DATA, input, LANES*WIDTH bits: lane data of the offered transfer.
REQ-011 The block SHALL provide port OUT_VALID, output, 1 bit: the stage holds a transfer.
REQ-012 The block SHALL provide port OUT_READY, input, 1 bit: downstream accepts.
REQ-013 The block SHALL provide port OUT_CTRL, output, CTRL_W bits: control bits of the head entry.
REQ-014 The block SHALL provide port OUT_DATA, output, LANES*WIDTH bits: lane data of the head entry.
REQ-015 The block SHALL provide port OCCUPANCY, output, 2 bits: number of held entries (0 to 2).
REQ-016 The block SHALL provide port STALL_CNT, output, 16 bits: statistics counter (see Configuration).
REQ-017 The block SHALL provide port FLUSH_CNT, output, 16 bits: statistics counter (see Configuration).

Function
REQ-018 The block SHALL be a two-entry skid buffer, with a MAIN register driving the OUT_* ports and a SKID register, and state EMPTY, ONE or TWO.
REQ-019 An input transfer SHALL occur when IN_VALID and IN_READY are both high at the falling edge; an output transfer SHALL occur when OUT_VALID and OUT_READY are both high at the falling edge.
REQ-020 IN_READY SHALL be high exactly when the state is not TWO, and SHALL be decoded from the state register only, with no combinational path from OUT_READY.
REQ-021 OUT_VALID SHALL be high exactly when the state is not EMPTY; OCCUPANCY SHALL be 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-022 In EMPTY, an input transfer SHALL load MAIN and move the state to ONE.
REQ-023 In ONE, an input transfer with no output transfer SHALL load SKID and move the state to TWO.
REQ-024 In ONE, an output transfer with no input transfer SHALL move the state to EMPTY.
REQ-025 In ONE, simultaneous input and output transfers SHALL load MAIN with the input and keep the state at ONE.
REQ-026 In TWO, an output transfer SHALL copy SKID into MAIN and move the state to ONE; no input is accepted in TWO.
REQ-027 Latency SHALL be one falling edge from input transfer to OUT_VALID when the stage is empty; order SHALL be strictly FIFO.
REQ-028 OUT_CTRL SHALL be forced to all zeros whenever OUT_VALID is low, so that a bubble never asserts a control bit.
REQ-029 With OUT_VALID high and OUT_READY low, OUT_CTRL and OUT_DATA SHALL stay stable until the output transfer.
REQ-030 FLUSH high at a falling edge SHALL move the state to EMPTY and clear MAIN and SKID to zero; FLUSH SHALL override any simultaneous input or output transfer, and the offered input is dropped.

Reset
REQ-031 CLR high SHALL immediately, without waiting for a clock edge, force the state to EMPTY, MAIN, SKID and both counters to zero, OUT_VALID and OUT_CTRL to 0, and IN_READY to 1.
REQ-032 CLR asserted mid-operation, including in state TWO, SHALL discard both entries; the first falling edge after CLR is released SHALL operate normally.

Configuration
REQ-033 With macro PIPE_STAGE_STATS_EN defined, STALL_CNT SHALL count falling edges with OUT_VALID high and OUT_READY low, and FLUSH_CNT SHALL count falling edges with FLUSH high; both counters SHALL saturate at 16'hFFFF.
REQ-034 Without PIPE_STAGE_STATS_EN, STALL_CNT and FLUSH_CNT SHALL be tied to constant 0, no counter logic SHALL be present, and all other behaviour SHALL be unchanged.

Verification
REQ-035 Pass-through: LANES=2, OUT_READY held 1, in {ctrl=2'b11, data=64'h0000_0005_0000_0007} -> after one falling edge OUT_VALID=1 with the same ctrl and data, and OCCUPANCY=1.
REQ-036 Backpressure: OUT_READY=0, send A=1 then B=2 -> OCCUPANCY=2, IN_READY=0, OUT_DATA=1; set OUT_READY=1 -> outputs 1 then 2 on consecutive edges, IN_READY=1.
REQ-037 Simultaneous: in ONE holding 3, input 4 with OUT_READY=1 -> state stays ONE, OUT_DATA=4, no entry lost.
REQ-038 Flush: in TWO, FLUSH=1 together with IN_VALID=1 -> OCCUPANCY=0, OUT_CTRL=0, OUT_DATA=0; FLUSH_CNT=1 when stats are enabled.
REQ-039 Async reset: in TWO, assert CLR between clock edges -> outputs zero and IN_READY=1 before the next edge.
REQ-040 Saturation: with stats enabled, hold a stall for 70000 edges -> STALL_CNT=16'hFFFF; with stats disabled -> STALL_CNT=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Two-entry skid buffer used as a pipeline stage register. MAIN drives the
// OUT_* ports and SKID catches the one transfer that can arrive while
// downstream is stalled. IN_READY is decoded from the state register only,
// so there is no combinational path from OUT_READY back to IN_READY.
// All state updates happen on the falling edge of CLK.
//
// Optional feature: define PIPE_STAGE_STATS_EN to build the saturating
// STALL_CNT / FLUSH_CNT statistics counters. Without it both ports are
// tied to zero.
//
// Parameters
//   WIDTH   bits per data lane
//   LANES   data lanes per transfer (lane 0 = bits WIDTH-1:0)
//   CTRL_W  width of the control-bit bundle
//
// Ports
//   CLK        stage clock (falling-edge active)
//   CLR        asynchronous active-high reset
//   FLUSH      synchronous bubble insertion, drops everything held
//   IN_VALID   upstream offers a transfer
//   IN_READY   stage can accept a transfer
//   IN_CTRL    control bits of the offered transfer
//   IN_DATA    lane data of the offered transfer
//   OUT_VALID  stage holds a transfer
//   OUT_READY  downstream accepts
//   OUT_CTRL   control bits of the head entry (zero when OUT_VALID is low)
//   OUT_DATA   lane data of the head entry
//   OCCUPANCY  number of held entries (0..2)
//   STALL_CNT  edges with OUT_VALID high and OUT_READY low (stats build)
//   FLUSH_CNT  edges with FLUSH high (stats build)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 2,
    parameter int CTRL_W = 2
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [CTRL_W-1:0]        IN_CTRL,
    input  logic [LANES*WIDTH-1:0]   IN_DATA,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [CTRL_W-1:0]        OUT_CTRL,
    output logic [LANES*WIDTH-1:0]   OUT_DATA,
    output logic [1:0]               OCCUPANCY,
    output logic [15:0]              STALL_CNT,
    output logic [15:0]              FLUSH_CNT
);

    localparam int DW = LANES * WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_p0;
    state_t             state_nxt;

    logic [CTRL_W-1:0]  main_ctrl_p0;
    logic [DW-1:0]      main_data_p0;
    logic [CTRL_W-1:0]  skid_ctrl_p0;
    logic [DW-1:0]      skid_data_p0;

    logic               vld_p0;
    logic               in_xfer;
    logic               out_xfer;

    logic               load_main_in;
    logic               load_skid;
    logic               move_skid;
    logic               clear_all;

    assign vld_p0    = (state_p0 != EMPTY);
    assign IN_READY  = (state_p0 != TWO);
    assign OUT_VALID = vld_p0;
    assign OUT_CTRL  = vld_p0 ? main_ctrl_p0 : '0;
    assign OUT_DATA  = main_data_p0;
    assign OCCUPANCY = (state_p0 == TWO) ? 2'd2 :
                       (state_p0 == ONE) ? 2'd1 : 2'd0;

    assign in_xfer   = IN_VALID & IN_READY;
    assign out_xfer  = vld_p0 & OUT_READY;

    // Next-state and register-load decode
    always_comb begin
        state_nxt    = state_p0;
        load_main_in = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        clear_all    = 1'b0;
        if (FLUSH) begin
            // Flush wins over any transfer; the offered input is dropped.
            state_nxt = EMPTY;
            clear_all = 1'b1;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_nxt = ONE;
                        move_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Stage p0: state register
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state_p0 <= EMPTY;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Stage p0: MAIN / SKID entries
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            main_ctrl_p0 <= '0;
            main_data_p0 <= '0;
            skid_ctrl_p0 <= '0;
            skid_data_p0 <= '0;
        end else if (clear_all) begin
            main_ctrl_p0 <= '0;
            main_data_p0 <= '0;
            skid_ctrl_p0 <= '0;
            skid_data_p0 <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl_p0 <= IN_CTRL;
                main_data_p0 <= IN_DATA;
            end else if (move_skid) begin
                main_ctrl_p0 <= skid_ctrl_p0;
                main_data_p0 <= skid_data_p0;
            end
            if (load_skid) begin
                skid_ctrl_p0 <= IN_CTRL;
                skid_data_p0 <= IN_DATA;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt_p0;
    logic [15:0] flush_cnt_p0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: statistics counters
    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_cnt_p0 <= '0;
            flush_cnt_p0 <= '0;
        end else begin
            if (vld_p0 && !OUT_READY) begin
                stall_cnt_p0 <= sat_inc(stall_cnt_p0);
            end
            if (FLUSH) begin
                flush_cnt_p0 <= sat_inc(flush_cnt_p0);
            end
        end
    end

    assign STALL_CNT = stall_cnt_p0;
    assign FLUSH_CNT = flush_cnt_p0;
`else
    assign STALL_CNT = 16'd0;
    assign FLUSH_CNT = 16'd0;
`endif

endmodule
